tli_monitor: RTL and testbench
==============================

Name: tli_monitor

Overview:
- Passive checker at the lamp end of the four-road traffic-light controller.
- Samples the R/Y/G lamp buses on each phase tick, locks onto the rotation, tracks active road and phase timing, and flags any illegal lamp pattern, timing or order violation.
- Drives a 7-segment digit with elapsed phase ticks, or "F" on fault.
- Sits beside the controller and lamp drivers as a safety/debug monitor.

Parameters:
- GREEN_TICKS, 5, ticks a road must show green per phase (1..7).
- YELLOW_TICKS, 3, ticks a road must show yellow per phase (1..7).

Ports:
- clkin  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- tick  input  1  one-clkin-cycle strobe marking a controller phase step; lamps are sampled only when tick=1.
- R  input  4  red lamps, active-low-lit (0 = road has right of way); road k is bit 3-k.
- Y  input  4  yellow lamps, 1 = lit; road k is bit 3-k.
- G  input  4  green lamps, 1 = lit; road k is bit 3-k.
- phase  output  2  road index currently holding right of way.
- locked  output  1  monitor synchronised to the rotation.
- fault  output  1  sticky fault flag.
- fault_code  output  3  first fault cause.
- cycle_cnt  output  8  completed full rotations (road 3 to road 0), wraps 255 to 0.
- seg  output  7  segments abcdefg, active-high.

Behaviour:
- Reset values: phase=0, locked=0, fault=0, fault_code=0, cycle_cnt=0, seg=0 digit (1111110), state=SYNC, elapsed=0, prev_yellow_valid=0.
- rst has priority over tick when both are asserted in the same cycle.
- Cycles with tick=0 hold all state. All outputs are registered and reflect a tick sample on the next clkin edge (latency 1).
- Legal pattern: exactly one R bit is 0, at road k. Exactly one of G[k]/Y[k] is 1. All other G/Y bits are 0.
- Fault codes: 1 PATTERN, 2 SHORT_GREEN, 3 LONG_GREEN, 4 SHORT_YELLOW, 5 LONG_YELLOW, 6 ORDER.
- Priority when several causes hit in one sample: PATTERN, then ORDER, then timing.

State machine (evaluated on tick samples only):

- SYNC:
  - Illegal samples are ignored (no fault) and clear prev_yellow_valid.
  - A legal yellow on road j sets prev_yellow_valid and records j.
  - A legal green on road k with prev_yellow_valid and j == k-1 (mod 4) goes to GREEN with phase=k, elapsed=1, locked=1.
  - A legal green without a matching previous yellow stays in SYNC and clears prev_yellow_valid.

- GREEN:
  - Green on phase road:
    - If elapsed == GREEN_TICKS, fault LONG_GREEN.
    - Otherwise elapsed+1.
  - Yellow on phase road:
    - If elapsed != GREEN_TICKS, fault SHORT_GREEN.
    - Otherwise go to YELLOW with elapsed=1.
  - Active road != phase: fault ORDER.

- YELLOW:
  - Yellow on phase road:
    - If elapsed == YELLOW_TICKS, fault LONG_YELLOW.
    - Otherwise elapsed+1.
  - Green on road phase+1 (mod 4):
    - If elapsed != YELLOW_TICKS, fault SHORT_YELLOW.
    - Otherwise phase+1, elapsed=1, go to GREEN; if phase was 3, cycle_cnt+1 (8-bit wrap).
  - Any other active road or green on the phase road: fault ORDER.

- FAULT:
  - Entered from GREEN/YELLOW on any fault or any illegal pattern.
  - fault=1; fault_code latched with the first cause.
  - phase, cycle_cnt and locked are frozen.
  - Leaves only on rst.

- elapsed is 3 bits and never exceeds 7; parameters are capped at 7.
- seg shows the BCD digit of elapsed:
  - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001, 4 = 0110011, 5 = 1011011, 6 = 1011111, 7 = 1110000.
  - In FAULT, seg = 1000111 ("F").
- Reset mid-phase or in FAULT returns to SYNC; relock requires a fresh yellow-to-green boundary.

Test Plan:
- Reset, no ticks for 20 cycles -> locked=0, fault=0, phase=0, cycle_cnt=0, seg=1111110.
- Nominal stimulus: 5 green + 3 yellow ticks per road, roads 0..3, two and a half rotations, ticks every 4 clkin cycles -> locked=1 one cycle after the first yellow3-to-green0 sample. Then phase steps 0,1,2,3, seg counts 1..5 then 1..3, cycle_cnt=1 after the next road3-to-road0 boundary, fault stays 0.
- After lock, road 1 gets only 4 green ticks then yellow -> fault=1, fault_code=2, seg=1000111. Further legal ticks leave phase=1 frozen.
- After lock, sample R=0011 (two roads active) -> fault_code=1. Pulse rst -> all outputs return to reset values and a nominal sequence relocks.
- After lock, yellow on road 2 followed by green on road 0 -> fault_code=6. Yellow held for 4 ticks in another run -> fault_code=5.
- rst and tick asserted in the same cycle with an illegal pattern -> reset values, no fault. Lamp changes with tick=0 -> no state change.

Source files
------------

// File: rtl/tli_monitor.sv
// tli_monitor: passive checker at the lamp end of a four-road traffic-light
// controller. Locks onto the yellow-to-green rotation, tracks the active road
// and phase timing, latches the first fault, and shows elapsed ticks (or "F")
// on a 7-segment digit.
module tli_monitor #(
  parameter int GREEN_TICKS  = 5,
  parameter int YELLOW_TICKS = 3
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic       tick,
  input  logic [3:0] R,
  input  logic [3:0] Y,
  input  logic [3:0] G,
  output logic [1:0] phase,
  output logic       locked,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [7:0] cycle_cnt,
  output logic [6:0] seg
);

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_FAULT  = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    FC_NONE         = 3'd0,
    FC_PATTERN      = 3'd1,
    FC_SHORT_GREEN  = 3'd2,
    FC_LONG_GREEN   = 3'd3,
    FC_SHORT_YELLOW = 3'd4,
    FC_LONG_YELLOW  = 3'd5,
    FC_ORDER        = 3'd6
  } fault_e;

  // Phase lengths saturate at 7 so they always fit the 3-bit elapsed counter.
  localparam logic [2:0] G_LIM = (GREEN_TICKS  > 7) ? 3'd7 : 3'(GREEN_TICKS);
  localparam logic [2:0] Y_LIM = (YELLOW_TICKS > 7) ? 3'd7 : 3'(YELLOW_TICKS);

  localparam logic [6:0] SEG_FAULT = 7'b1000111;

  state_e      state_q, state_d;
  logic [2:0]  elapsed_q, elapsed_d;
  logic [1:0]  phase_q, phase_d;
  logic        locked_q, locked_d;
  logic        fault_q, fault_d;
  fault_e      fault_code_q, fault_code_d;
  logic [7:0]  cycle_cnt_q, cycle_cnt_d;
  logic        prev_yellow_valid_q, prev_yellow_valid_d;
  logic [1:0]  prev_road_q, prev_road_d;
  logic [6:0]  seg_q, seg_d;

  logic [3:0]  act, grn, yel;
  logic        legal;
  logic        is_green;
  logic [1:0]  act_road;

  // Remap lamp buses to road order (road k lives in bit 3-k) and classify the sample.
  always_comb begin
    // NOTE: every variable assigned here gets a value on every path first, so no latch is inferred.
    act      = '0;
    grn      = '0;
    yel      = '0;
    act_road = '0;
    for (int k = 0; k < 4; k++) begin
      act[k] = ~R[3-k];
      grn[k] = G[3-k];
      yel[k] = Y[3-k];
    end
    for (int k = 0; k < 4; k++) begin
      if (act[k]) act_road = 2'(k);
    end
    legal    = $onehot(act) && ((grn | yel) == act) && ((grn & yel) == 4'b0000);
    is_green = |(grn & act);
  end

  // Next-state logic: only a tick sample can move the monitor.
  always_comb begin
    state_d             = state_q;
    elapsed_d           = elapsed_q;
    phase_d             = phase_q;
    locked_d            = locked_q;
    fault_d             = fault_q;
    fault_code_d        = fault_code_q;
    cycle_cnt_d         = cycle_cnt_q;
    prev_yellow_valid_d = prev_yellow_valid_q;
    prev_road_d         = prev_road_q;

    if (tick) begin
      unique case (state_q)
        ST_SYNC: begin
          if (!legal) begin
            prev_yellow_valid_d = 1'b0;
          end else if (!is_green) begin
            prev_yellow_valid_d = 1'b1;
            prev_road_d         = act_road;
          end else if (prev_yellow_valid_q && (prev_road_q == act_road - 2'd1)) begin
            state_d             = ST_GREEN;
            phase_d             = act_road;
            elapsed_d           = 3'd1;
            locked_d            = 1'b1;
            prev_yellow_valid_d = 1'b0;
          end else begin
            prev_yellow_valid_d = 1'b0;
          end
        end

        ST_GREEN: begin
          if (!legal) begin
            fault_code_d = FC_PATTERN;
          end else if (act_road != phase_q) begin
            fault_code_d = FC_ORDER;
          end else if (is_green) begin
            if (elapsed_q == G_LIM) fault_code_d = FC_LONG_GREEN;
            else                    elapsed_d    = elapsed_q + 3'd1;
          end else begin
            if (elapsed_q != G_LIM) begin
              fault_code_d = FC_SHORT_GREEN;
            end else begin
              state_d   = ST_YELLOW;
              elapsed_d = 3'd1;
            end
          end
        end

        ST_YELLOW: begin
          if (!legal) begin
            fault_code_d = FC_PATTERN;
          end else if (!is_green && (act_road == phase_q)) begin
            if (elapsed_q == Y_LIM) fault_code_d = FC_LONG_YELLOW;
            else                    elapsed_d    = elapsed_q + 3'd1;
          end else if (is_green && (act_road == phase_q + 2'd1)) begin
            if (elapsed_q != Y_LIM) begin
              fault_code_d = FC_SHORT_YELLOW;
            end else begin
              state_d   = ST_GREEN;
              phase_d   = phase_q + 2'd1;
              elapsed_d = 3'd1;
              if (phase_q == 2'd3) cycle_cnt_d = cycle_cnt_q + 8'd1;
            end
          end else begin
            fault_code_d = FC_ORDER;
          end
        end

        default: ; // ST_FAULT holds everything until reset
      endcase

      // Any cause raised above while tracking moves the monitor into FAULT.
      if (state_q != ST_FAULT && fault_code_d != FC_NONE) begin
        state_d = ST_FAULT;
        fault_d = 1'b1;
      end
    end
  end

  // Display decode from the next state so seg lines up with the other outputs.
  always_comb begin
    seg_d = 7'b1111110;
    if (state_d == ST_FAULT) begin
      seg_d = SEG_FAULT;
    end else begin
      unique case (elapsed_d)
        3'd0: seg_d = 7'b1111110;
        3'd1: seg_d = 7'b0110000;
        3'd2: seg_d = 7'b1101101;
        3'd3: seg_d = 7'b1111001;
        3'd4: seg_d = 7'b0110011;
        3'd5: seg_d = 7'b1011011;
        3'd6: seg_d = 7'b1011111;
        3'd7: seg_d = 7'b1110000;
        default: seg_d = 7'b1111110;
      endcase
    end
  end

  // State and output registers; reset wins over a simultaneous tick.
  always_ff @(posedge clkin) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q             <= ST_SYNC;
      elapsed_q           <= '0;
      phase_q             <= '0;
      locked_q            <= 1'b0;
      fault_q             <= 1'b0;
      fault_code_q        <= FC_NONE;
      cycle_cnt_q         <= '0;
      prev_yellow_valid_q <= 1'b0;
      prev_road_q         <= '0;
      seg_q               <= 7'b1111110;
    end else begin
      state_q             <= state_d;
      elapsed_q           <= elapsed_d;
      phase_q             <= phase_d;
      locked_q            <= locked_d;
      fault_q             <= fault_d;
      fault_code_q        <= fault_code_d;
      cycle_cnt_q         <= cycle_cnt_d;
      prev_yellow_valid_q <= prev_yellow_valid_d;
      prev_road_q         <= prev_road_d;
      seg_q               <= seg_d;
    end
  end

  assign phase      = phase_q;
  assign locked     = locked_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;
  assign cycle_cnt  = cycle_cnt_q;
  assign seg        = seg_q;

endmodule

// File: tb/tb_tli_monitor.sv
// Directed testbench for tli_monitor: nominal rotation, each fault cause,
// reset/tick priority and tick gating, with hand-computed expectations.
module tb_tli_monitor;

  logic       clkin = 1'b0;
  logic       rst   = 1'b1;
  logic       tick  = 1'b0;
  logic [3:0] R     = 4'hF;
  logic [3:0] Y     = 4'h0;
  logic [3:0] G     = 4'h0;
  logic [1:0] phase;
  logic       locked;
  logic       fault;
  logic [2:0] fault_code;
  logic [7:0] cycle_cnt;
  logic [6:0] seg;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [6:0] SEG_F = 7'b1000111;

  tli_monitor #(.GREEN_TICKS(5), .YELLOW_TICKS(3)) dut (
    .clkin      (clkin),
    .rst        (rst),
    .tick       (tick),
    .R          (R),
    .Y          (Y),
    .G          (G),
    .phase      (phase),
    .locked     (locked),
    .fault      (fault),
    .fault_code (fault_code),
    .cycle_cnt  (cycle_cnt),
    .seg        (seg)
  );

  always #5 clkin = ~clkin;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_digit(input int n);
    case (n)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      default: return 7'bxxxxxxx;
    endcase
  endfunction

  // One tick every four clkin cycles; outputs are sampled at the negedge after the capturing posedge.
  task automatic drive_tick(input logic [3:0] r, input logic [3:0] y, input logic [3:0] g);
    repeat (2) @(negedge clkin);
    @(negedge clkin);
    R = r; Y = y; G = g; tick = 1'b1;
    @(negedge clkin);
    tick = 1'b0;
  endtask

  task automatic lamp(input int k, input bit is_yel);
    logic [3:0] m;
    m = 4'b1000 >> k;
    drive_tick(~m, is_yel ? m : 4'b0000, is_yel ? 4'b0000 : m);
  endtask

  task automatic do_reset();
    @(negedge clkin);
    rst = 1'b1; tick = 1'b0; R = 4'hF; Y = 4'h0; G = 4'h0;
    repeat (2) @(negedge clkin);
    rst = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_phase"},  32'(phase),      32'd0);
    check({tag, "_locked"}, 32'(locked),     32'd0);
    check({tag, "_fault"},  32'(fault),      32'd0);
    check({tag, "_code"},   32'(fault_code), 32'd0);
    check({tag, "_cyc"},    32'(cycle_cnt),  32'd0);
    check({tag, "_seg"},    32'(seg),        32'(7'b1111110));
  endtask

  // ng green then ny yellow ticks on road k; when tracking, each sample is checked.
  task automatic road_phase(input int k, input int ng, input int ny, input bit trk, input int cyc);
    for (int i = 1; i <= ng; i++) begin
      lamp(k, 1'b0);
      if (trk) begin
        check($sformatf("g_phase_r%0d_%0d", k, i), 32'(phase),     32'(k));
        check($sformatf("g_seg_r%0d_%0d", k, i),   32'(seg),       32'(seg_digit(i)));
        check($sformatf("g_lock_r%0d_%0d", k, i),  32'(locked),    32'd1);
        check($sformatf("g_flt_r%0d_%0d", k, i),   32'(fault),     32'd0);
        check($sformatf("g_cyc_r%0d_%0d", k, i),   32'(cycle_cnt), 32'(cyc));
      end
    end
    for (int i = 1; i <= ny; i++) begin
      lamp(k, 1'b1);
      if (trk) begin
        check($sformatf("y_phase_r%0d_%0d", k, i), 32'(phase), 32'(k));
        check($sformatf("y_seg_r%0d_%0d", k, i),   32'(seg),   32'(seg_digit(i)));
        check($sformatf("y_flt_r%0d_%0d", k, i),   32'(fault), 32'd0);
      end
    end
    if (!trk) begin
      check($sformatf("sync_lock_r%0d", k), 32'(locked), 32'd0);
      check($sformatf("sync_seg_r%0d", k),  32'(seg),    32'(seg_digit(0)));
    end
  endtask

  task automatic acquire();
    road_phase(3, 5, 3, 1'b0, 0);
  endtask

  task automatic check_fault(input string tag, input int code, input int ph);
    check({tag, "_fault"}, 32'(fault),      32'd1);
    check({tag, "_code"},  32'(fault_code), 32'(code));
    check({tag, "_seg"},   32'(seg),        32'(SEG_F));
    check({tag, "_phase"}, 32'(phase),      32'(ph));
    check({tag, "_lock"},  32'(locked),     32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and idle without ticks.
    do_reset();
    repeat (20) @(negedge clkin);
    check_reset_vals("idle");

    // Nominal: acquire on yellow3->green0, then two and a half rotations.
    acquire();
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 4; k++)
        road_phase(k, 5, 3, 1'b1, r);
    road_phase(0, 5, 3, 1'b1, 2);
    road_phase(1, 5, 3, 1'b1, 2);

    // Short green on road 1; later legal ticks leave everything frozen.
    do_reset();
    acquire();
    road_phase(0, 5, 3, 1'b1, 0);
    road_phase(1, 4, 0, 1'b1, 0);
    lamp(1, 1'b1);
    check_fault("short_g", 2, 1);
    lamp(1, 1'b1);
    lamp(1, 1'b1);
    lamp(2, 1'b0);
    check_fault("short_g_frozen", 2, 1);

    // Illegal pattern (two roads active), then reset and relock.
    do_reset();
    acquire();
    lamp(0, 1'b0);
    drive_tick(4'b0011, 4'b0000, 4'b1100);
    check_fault("pattern", 1, 0);
    do_reset();
    check_reset_vals("post_fault_rst");
    acquire();
    lamp(0, 1'b0);
    check("relock_locked", 32'(locked), 32'd1);
    check("relock_phase",  32'(phase),  32'd0);
    check("relock_seg",    32'(seg),    32'(seg_digit(1)));

    // Yellow on road 2 followed by green on road 0.
    do_reset();
    acquire();
    road_phase(0, 5, 3, 1'b1, 0);
    road_phase(1, 5, 3, 1'b1, 0);
    road_phase(2, 5, 1, 1'b1, 0);
    lamp(0, 1'b0);
    check_fault("order_y", 6, 2);

    // Yellow held for four ticks.
    do_reset();
    acquire();
    road_phase(0, 5, 3, 1'b1, 0);
    lamp(0, 1'b1);
    check_fault("long_y", 5, 0);

    // Green held for six ticks.
    do_reset();
    acquire();
    road_phase(0, 5, 0, 1'b1, 0);
    lamp(0, 1'b0);
    check_fault("long_g", 3, 0);

    // Only two yellow ticks before the next green.
    do_reset();
    acquire();
    road_phase(0, 5, 2, 1'b1, 0);
    lamp(1, 1'b0);
    check_fault("short_y", 4, 0);

    // Wrong road goes green in the middle of a green phase.
    do_reset();
    acquire();
    road_phase(0, 2, 0, 1'b1, 0);
    lamp(2, 1'b0);
    check_fault("order_g", 6, 0);

    // Reset and tick together with an illegal pattern: reset wins.
    do_reset();
    acquire();
    lamp(0, 1'b0);
    @(negedge clkin);
    rst = 1'b1; tick = 1'b1; R = 4'b0000; Y = 4'hF; G = 4'hF;
    @(negedge clkin);
    rst = 1'b0; tick = 1'b0;
    check_reset_vals("rst_tick");

    // Lamp activity with tick low must not move the monitor.
    acquire();
    lamp(0, 1'b0);
    lamp(0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clkin);
      R = 4'(i * 5); Y = 4'hF - 4'(i); G = 4'(i * 3);
    end
    @(negedge clkin);
    R = 4'b0111; Y = 4'b1000; G = 4'b0000;
    repeat (2) @(negedge clkin);
    check("gate_fault", 32'(fault),  32'd0);
    check("gate_phase", 32'(phase),  32'd0);
    check("gate_seg",   32'(seg),    32'(seg_digit(2)));
    check("gate_lock",  32'(locked), 32'd1);
    lamp(0, 1'b0);
    check("gate_resume_seg", 32'(seg), 32'(seg_digit(3)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
